// File: rtl/execute_stage.sv
// EX stage of the GCD CPU: single-cycle ALU plus a restoring divider that runs
// one bit per cycle and stalls upstream. Define EX_OVERFLOW_EN to flag ADD/SUB signed overflow.
module execute_stage #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             DX_MemtoReg,
  input  logic             DX_RegWrite,
  input  logic             DX_MemRead,
  input  logic             DX_MemWrite,
  input  logic [3:0]       DX_ALUctr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] DX_MD,
  input  logic [4:0]       DX_RD,
  output logic             stall,
  output logic             ovf,
  output logic             XM_MemtoReg,
  output logic             XM_RegWrite,
  output logic             XM_MemRead,
  output logic             XM_MemWrite,
  output logic [WIDTH-1:0] ALUout,
  output logic [WIDTH-1:0] XM_MD,
  output logic [4:0]       XM_RD
);

  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             op_div;
  logic             l_memtoreg, l_regwrite, l_memread, l_memwrite;
  logic [WIDTH-1:0] l_md;
  logic [4:0]       l_rd;

  logic             mc, last;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             ovf_hit;
  logic [WIDTH:0]   rem_sh, rem_diff;
  logic             geq;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  assign mc   = ((DX_ALUctr == 4'd7) || (DX_ALUctr == 4'd8)) && (B != '0);
  assign last = (cnt == LAST);
  assign sum  = A + B;
  assign diff = A - B;

`ifdef EX_OVERFLOW_EN
  always_comb begin
    ovf_hit = 1'b0;
    if (DX_ALUctr == 4'd0)
      ovf_hit = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    else if (DX_ALUctr == 4'd1)
      ovf_hit = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
  end
`else
  assign ovf_hit = 1'b0;
`endif

  // B = 0 divide/remainder resolves here in one cycle
  always_comb begin
    alu_res = '0;
    case (DX_ALUctr)
      4'd0: alu_res = sum;
      4'd1: alu_res = diff;
      4'd2: alu_res = A & B;
      4'd3: alu_res = A | B;
      4'd4: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'd5: alu_res = A << B[4:0];
      4'd6: alu_res = A >> B[4:0];
      4'd7: alu_res = A;
      4'd8: alu_res = '1;
      default: alu_res = '0;
    endcase
  end

  // Restoring step; the extra top bit keeps the shifted remainder exact for divisors >= 2^(WIDTH-1)
  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, dvs};
    geq      = ~rem_diff[WIDTH];
    rem_nx   = geq ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx   = {quo[WIDTH-2:0], geq};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mc) state_d = BUSY;
      BUSY:    if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    if (!rst)
      stall = ((state_q == IDLE) && mc) || ((state_q == BUSY) && !last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      op_div      <= 1'b0;
      l_memtoreg  <= 1'b0;
      l_regwrite  <= 1'b0;
      l_memread   <= 1'b0;
      l_memwrite  <= 1'b0;
      l_md        <= '0;
      l_rd        <= '0;
      ovf         <= 1'b0;
      XM_MemtoReg <= 1'b0;
      XM_RegWrite <= 1'b0;
      XM_MemRead  <= 1'b0;
      XM_MemWrite <= 1'b0;
      ALUout      <= '0;
      XM_MD       <= '0;
      XM_RD       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mc) begin
            quo         <= A;
            rem         <= '0;
            dvs         <= B;
            op_div      <= (DX_ALUctr == 4'd8);
            cnt         <= '0;
            l_memtoreg  <= DX_MemtoReg;
            l_regwrite  <= DX_RegWrite;
            l_memread   <= DX_MemRead;
            l_memwrite  <= DX_MemWrite;
            l_md        <= DX_MD;
            l_rd        <= DX_RD;
            ovf         <= 1'b0;
            XM_MemtoReg <= 1'b0;
            XM_RegWrite <= 1'b0;
            XM_MemRead  <= 1'b0;
            XM_MemWrite <= 1'b0;
          end else begin
            ALUout      <= alu_res;
            ovf         <= ovf_hit;
            XM_MemtoReg <= DX_MemtoReg;
            XM_RegWrite <= DX_RegWrite & ~ovf_hit;
            XM_MemRead  <= DX_MemRead;
            XM_MemWrite <= DX_MemWrite;
            XM_MD       <= DX_MD;
            XM_RD       <= DX_RD;
          end
        end
        BUSY: begin
          rem <= rem_nx;
          quo <= quo_nx;
          ovf <= 1'b0;
          if (last) begin
            cnt         <= '0;
            ALUout      <= op_div ? quo_nx : rem_nx;
            XM_MemtoReg <= l_memtoreg;
            XM_RegWrite <= l_regwrite;
            XM_MemRead  <= l_memread;
            XM_MemWrite <= l_memwrite;
            XM_MD       <= l_md;
            XM_RD       <= l_rd;
          end else begin
            cnt         <= cnt + 1'b1;
            XM_MemtoReg <= 1'b0;
            XM_RegWrite <= 1'b0;
            XM_MemRead  <= 1'b0;
            XM_MemWrite <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: driver pushes reference results, monitor pops on every
// non-bubble XM output. Honours EX_OVERFLOW_EN the same way as the design.
module tb_execute_stage;
  localparam int WIDTH = 32;

`ifdef EX_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite;
  logic [3:0]       DX_ALUctr;
  logic [WIDTH-1:0] A, B, DX_MD;
  logic [4:0]       DX_RD;
  logic             stall, ovf;
  logic             XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite;
  logic [WIDTH-1:0] ALUout, XM_MD;
  logic [4:0]       XM_RD;

  execute_stage #(.WIDTH(WIDTH), .CW(6)) dut (
    .clk(clk), .rst(rst),
    .DX_MemtoReg(DX_MemtoReg), .DX_RegWrite(DX_RegWrite),
    .DX_MemRead(DX_MemRead), .DX_MemWrite(DX_MemWrite),
    .DX_ALUctr(DX_ALUctr), .A(A), .B(B), .DX_MD(DX_MD), .DX_RD(DX_RD),
    .stall(stall), .ovf(ovf),
    .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite),
    .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite),
    .ALUout(ALUout), .XM_MD(XM_MD), .XM_RD(XM_RD)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] md;
    logic [4:0]  rd;
    logic [3:0]  ctl;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return (b == 0) ? a : a % b;
      4'd8: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'd0)      r = sa + sb;
    else if (op == 4'd1) r = sa - sb;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Monitor: any non-bubble XM cycle must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1 && (XM_MemtoReg | XM_RegWrite | XM_MemRead | XM_MemWrite) === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_output: got ALUout %h rd %0d with nothing expected", ALUout, XM_RD);
      end else begin
        e = q.pop_front();
        chk("alu_out", ALUout, e.alu);
        chk("xm_rd", {27'd0, XM_RD}, {27'd0, e.rd});
        chk("xm_md", XM_MD, e.md);
        chk("xm_ctl", {28'd0, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite}, {28'd0, e.ctl});
        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [2:0] cb, input bit abort);
    exp_t e;
    bit   is_mc, ov, consumed, s;
    int   hi;
    DX_ALUctr = op;
    A = a;
    B = b;
    DX_RD = rd;
    DX_MD = $urandom;
    {DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite} = {1'b1, cb};
    is_mc = (op == 4'd7 || op == 4'd8) && (b != 0);
    ov = OVF_EN && ref_ovf(op, a, b);
    e.alu = ref_alu(op, a, b);
    e.md  = DX_MD;
    e.rd  = rd;
    e.ctl = {1'b1, cb[2] & ~ov, cb[1], cb[0]};
    e.ovf = ov;
    e.cyc = cyc + (is_mc ? WIDTH + 1 : 1);
    if (abort) begin
      repeat (11) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_stall_async", {31'd0, stall}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_alu", ALUout, 32'd0);
      chk("rst_ctl", {28'd0, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite}, 32'd0);
      chk("rst_md_rd", XM_MD | {27'd0, XM_RD}, 32'd0);
      chk("rst_ovf_stall", {30'd0, ovf, stall}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      return;
    end
    q.push_back(e);
    hi = 0;
    consumed = 0;
    for (int i = 0; i < 200 && !consumed; i++) begin
      @(negedge clk);
      s = stall;
      if (s) hi++;
      @(posedge clk);
      #1;
      if (!s) consumed = 1;
      else begin
        A = $urandom;
        B = $urandom;
        DX_ALUctr = 4'($urandom_range(0, 15));
        DX_RD = 5'($urandom_range(0, 31));
        DX_MD = $urandom;
      end
    end
    if (!consumed) begin
      total++;
      bad++;
      $display("FAIL stall_timeout: op %0d never released, stall cycles %0d", op, hi);
    end
    chk("stall_cycles", hi, is_mc ? WIDTH : 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int sel;
    rst = 1'b1;
    {DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite} = 4'b0;
    DX_ALUctr = 4'd0; A = '0; B = '0; DX_MD = '0; DX_RD = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_alu", ALUout, 32'd0);
    chk("init_ctl", {28'd0, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite}, 32'd0);
    chk("init_ovf_stall", {30'd0, ovf, stall}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    do_op(4'd0, 32'd5, 32'd7, 5'd3, 3'b100, 0);
    do_op(4'd7, 32'd48, 32'd18, 5'd4, 3'b100, 0);
    do_op(4'd8, 32'd100, 32'd0, 5'd6, 3'b100, 0);
    do_op(4'd7, 32'd9, 32'd0, 5'd7, 3'b100, 0);
    do_op(4'd7, 32'd48, 32'd18, 5'd4, 3'b100, 0);
    do_op(4'd7, 32'd18, 32'd12, 5'd5, 3'b100, 0);
    do_op(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd8, 3'b100, 0);
    do_op(4'd1, 32'h8000_0000, 32'd1, 5'd9, 3'b100, 0);
    do_op(4'd8, 32'hFFFF_FFFF, 32'h8000_0001, 5'd10, 3'b101, 0);
    do_op(4'd7, 32'd1000, 32'd37, 5'd11, 3'b100, 1);
    do_op(4'd0, 32'd1, 32'd2, 5'd12, 3'b100, 0);
    do_op(4'd8, 32'd1000, 32'd37, 5'd13, 3'b100, 0);

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 3);
      ra = (sel == 1) ? 32'($urandom_range(0, 200)) : $urandom;
      case (sel)
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = $urandom;
        default: rb = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
      endcase
      do_op(4'($urandom_range(0, 15)), ra, rb, 5'($urandom_range(0, 31)),
            3'($urandom_range(0, 7)), 0);
    end

    {DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite} = 4'b0;
    DX_ALUctr = 4'd0;
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_output: got %0d results outstanding expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage GCD CPU pipeline. It sits between the DX pipeline register and the MEMORY stage, and produces ALUout, XM_MD, XM_RD and the XM_* control bits.
- Single-cycle ALU ops: ADD, SUB, AND, OR, SLT, SLL, SRL.
- Multi-cycle unsigned divide/remainder unit (restoring, 1 bit/cycle). It serves the GCD modulo loop and stalls upstream stages while busy.

Parameters:
WIDTH, 32, datapath width; the divider iteration count equals WIDTH.
CW, 6, width of the divider iteration counter; must satisfy 2^CW > WIDTH.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
DX_MemtoReg  input  1  control from ID/EX.
DX_RegWrite  input  1  control from ID/EX; 0 marks a bubble.
DX_MemRead  input  1  control from ID/EX.
DX_MemWrite  input  1  control from ID/EX.
DX_ALUctr  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed), 5 SLL, 6 SRL, 7 REMU, 8 DIVU; 9-15 give result 0.
A  input  WIDTH  operand A (rs).
B  input  WIDTH  operand B (rt or sign-extended immediate, muxed upstream).
DX_MD  input  WIDTH  store data.
DX_RD  input  5  destination register.
stall  output  1  hold PC, IF/ID and ID/EX; combinational.
ovf  output  1  registered signed-overflow flag (see Optional Feature).
XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite  output  1 each  registered control to MEMORY.
ALUout  output  WIDTH  registered result.
XM_MD  output  WIDTH  registered store data.
XM_RD  output  5  registered destination register.

Behaviour:
- Reset: all XM_* control = 0, ALUout = 0, XM_MD = 0, XM_RD = 0, ovf = 0, state = IDLE, counter = 0, stall = 0. Reset mid-division aborts it; no result is written.
- Single-cycle ops:
  - Registered at the next rising edge; latency 1 and stall = 0.
  - SLL/SRL shift A by B[4:0].
  - ADD/SUB wrap modulo 2^WIDTH.
  - XM_* control, XM_MD and XM_RD copy their DX_* inputs.
- Multi-cycle detect: mc = DX_ALUctr in {7,8} and B != 0.
- Divide by zero (B = 0) is single-cycle: REMU gives A, DIVU gives all-ones.
- FSM IDLE:
  - If mc: latch A, B, op and DX control, go to BUSY, counter = 0.
  - In that same edge, load XM with a bubble: all four XM_* control = 0. ALUout, XM_MD and XM_RD hold.
- FSM BUSY:
  - Each edge performs one restoring step: shift {rem, quo} left by 1, subtract divisor if rem >= divisor, set quotient bit; counter += 1.
  - XM stays a bubble while counter != WIDTH-1.
  - On the edge with counter == WIDTH-1: the final step completes; ALUout = rem (REMU) or quo (DIVU); XM control, XM_MD and XM_RD come from the latched copies; go to IDLE.
- Stall rule: stall = (IDLE && mc) || (BUSY && counter != WIDTH-1). Stall is low in the last BUSY cycle, so upstream advances on the same edge the result is written. Stall cycles per op = WIDTH (32); XM result appears WIDTH+1 cycles after issue.
- While BUSY, DX_* inputs are ignored.
- A back-to-back second REMU issued on the completion edge is seen in IDLE the next cycle and starts normally.

Optional Feature:
- Macro: EX_OVERFLOW_EN.
- Defined: for ADD/SUB, signed overflow sets ovf = 1 for that XM cycle and forces XM_RegWrite = 0; ALUout still holds the wrapped sum. ovf is 0 for all other ops and for bubbles.
- Undefined: ovf is tied 0; RegWrite is never suppressed.

Test Plan:
- Reset held 2 cycles mid-stream -> all XM outputs, ALUout and ovf are 0; stall = 0.
- ADD A=5, B=7, RD=3, RegWrite=1 -> next cycle ALUout = 12, XM_RD = 3, XM_RegWrite = 1, stall never high.
- REMU A=48, B=18, RD=4 -> stall high for exactly 32 cycles; XM bubble meanwhile; 33 cycles after issue ALUout = 12, XM_RegWrite = 1, XM_RD = 4.
- DIVU A=100, B=0 -> no stall; next cycle ALUout = 32'hFFFFFFFF. REMU A=9, B=0 -> ALUout = 9.
- GCD chain: REMU(48,18) followed immediately by REMU(18,12) -> results 12 then 6; second stall window starts the cycle after the first completes; no lost or duplicated result.
- EX_OVERFLOW_EN: ADD 32'h7FFFFFFF + 1 -> ALUout = 32'h80000000, ovf = 1, XM_RegWrite = 0. Without the macro: ovf = 0, XM_RegWrite = 1. Also: assert rst on BUSY cycle 10 -> IDLE and no result written.
